instr_fetch_buffer: RTL and testbench
=====================================

# instr_fetch_buffer

Instruction buffer between the CPU stimulus driver and the CPU core's instruction input. It accepts 32-bit instructions over a valid/ready handshake and stores them in a DEPTH-entry FIFO. It tags each entry with an RV32I legality flag and presents the oldest entry to the core. Free-running counters expose accepted and illegal instruction totals for the scoreboard.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CNT_W, 16, width of the statistics counters
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  buffer can accept this cycle
- instr  in  32  instruction word from upstream
- flush  in  1  synchronous discard of all buffered entries
- out_valid  out  1  head entry is valid
- out_ready  in  1  core consumes the head entry this cycle
- out_instr  out  32  head instruction word
- out_illegal  out  1  head entry failed the legality check
- count  out  $clog2(DEPTH)+1  current occupancy
- accepted_cnt  out  CNT_W  total instructions accepted, wraps
- illegal_cnt  out  CNT_W  total illegal instructions accepted, saturates

## Operation
- Push: in_valid && in_ready at a rising edge writes {illegal, instr} at the write pointer and advances the write pointer modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge advances the read pointer modulo DEPTH.
- in_ready = (count < DEPTH) && !flush. It depends only on registered state and flush, never on out_ready. When full, no push is allowed, even alongside a pop.
- out_valid = (count != 0). out_instr and out_illegal are driven from the entry at the read pointer. They are held stable while out_valid && !out_ready.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Legality is computed from instr at push time. The entry is legal only if instr[1:0] == 2'b11 and instr[6:0] is one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, 0001111. Otherwise illegal = 1.
- accepted_cnt increments by 1 on every push and wraps from 2^CNT_W−1 to 0.
- illegal_cnt increments on every push with illegal = 1 and saturates at 2^CNT_W−1.
- Flush: at the rising edge with flush = 1, both pointers and count go to 0. in_ready is 0 in that cycle, so nothing is pushed. A pop in that cycle is ignored. Statistics counters are not affected.
- Storage contents are not reset. Only pointers, count and counters are.

## Timing
- Reset values: in_ready = 1, out_valid = 0, count = 0, accepted_cnt = 0, illegal_cnt = 0. out_instr and out_illegal are don't-care while out_valid = 0.
- Reset asserted mid-operation immediately empties the buffer (asynchronous), discarding contents and zeroing counters. The first push can occur at the first rising edge after rst deasserts.
- Latency: an instruction pushed at edge N is visible on out_instr, with out_valid = 1, after edge N (same cycle as count update). It can be popped at edge N+1.
- Throughput: one push and one pop per cycle in steady state. With DEPTH ≥ 2, a continuously ready consumer never causes in_ready to drop.
- Full: after DEPTH pushes with no pop, in_ready = 0. It returns to 1 in the cycle after the first pop.

## Test plan
- Reset then push 0x00500093 (addi), with out_ready = 0 -> next cycle out_valid = 1, out_instr = 0x00500093, out_illegal = 0, count = 1, accepted_cnt = 1.
- Push 0x00000000 and 0xFFFFFFFF -> both popped with out_illegal = 1; illegal_cnt = 2, accepted_cnt = 2.
- With DEPTH = 4 and out_ready = 0, push 0x1, 0x2, 0x3, 0x4 (opcode-legal variants) -> count = 4, in_ready = 0. A fifth in_valid is not accepted. Then set out_ready = 1 -> words pop in order 1, 2, 3, 4, and in_ready rises the cycle after the first pop.
- Continuous in_valid/out_ready for 20 cycles with random legal words -> count stays ≤ 1, pop order matches push order, accepted_cnt = 20.
- Fill 3 entries, assert flush for one cycle while in_valid = 1 -> count = 0, out_valid = 0, the offered word is not accepted, and accepted_cnt is unchanged.
- Assert rst asynchronously between edges with 2 entries buffered -> out_valid, count, accepted_cnt and illegal_cnt drop to 0 before the next edge.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_buffer
// Purpose  : DEPTH-entry instruction FIFO with RV32I opcode legality tagging
//            and accepted / illegal instruction statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         accepted_cnt,
    output logic [CNT_W-1:0]         illegal_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0]    c_DEPTH   = CW'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Each entry holds {illegal, instr}
    logic [32:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_accepted_cnt;
    logic [CNT_W-1:0] r_illegal_cnt;

    logic w_opcode_ok;
    logic w_illegal;
    logic w_push;
    logic w_pop;

    always_comb begin
        w_opcode_ok = 1'b0;
        case (instr[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111, 7'b1110011, 7'b0001111: w_opcode_ok = 1'b1;
            default:                            w_opcode_ok = 1'b0;
        endcase
        w_illegal = !((instr[1:0] == 2'b11) && w_opcode_ok);
    end

    assign in_ready    = (r_count < c_DEPTH) && !flush;
    assign out_valid   = (r_count != '0);
    assign w_push      = in_valid && in_ready;
    // A pop coinciding with flush is swallowed by the flush itself
    assign w_pop       = out_valid && out_ready && !flush;

    assign out_instr    = r_mem[r_rd_ptr][31:0];
    assign out_illegal  = r_mem[r_rd_ptr][32];
    assign count        = r_count;
    assign accepted_cnt = r_accepted_cnt;
    assign illegal_cnt  = r_illegal_cnt;

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_illegal, instr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_accepted_cnt <= '0;
            r_illegal_cnt  <= '0;
        end else if (w_push) begin
            r_accepted_cnt <= r_accepted_cnt + CNT_W'(1);
            if (w_illegal && (r_illegal_cnt != c_CNT_MAX)) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_buffer
// Purpose  : Randomized and directed bench for instr_fetch_buffer against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int unsigned MAXC = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            instr;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_instr;
    logic                   out_illegal;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]       accepted_cnt;
    logic [CNT_W-1:0]       illegal_cnt;

    instr_fetch_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_illegal  (out_illegal),
        .count        (count),
        .accepted_cnt (accepted_cnt),
        .illegal_cnt  (illegal_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0]  q[$];
    int unsigned  m_acc = 0;
    int unsigned  m_ill = 0;

    logic [6:0] legal_ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f,
                                   7'h67, 7'h37, 7'h17, 7'h73, 7'h0f};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_illegal(input logic [31:0] w);
        if (w[1:0] != 2'b11) return 1'b1;
        foreach (legal_ops[i]) if (w[6:0] == legal_ops[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] legal_word();
        logic [31:0] r;
        r = $urandom();
        return {r[31:7], legal_ops[$urandom_range(0, 10)]};
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return $urandom();
            default: return legal_word();
        endcase
    endfunction

    task automatic compare_all();
        chk("count",     64'(count),        64'(q.size()));
        chk("out_valid", 64'(out_valid),    64'(q.size() != 0));
        chk("in_ready",  64'(in_ready),     64'((q.size() < DEPTH) && !flush));
        chk("acc_cnt",   64'(accepted_cnt), 64'(m_acc));
        chk("ill_cnt",   64'(illegal_cnt),  64'(m_ill));
        if (q.size() != 0) begin
            chk("out_instr",   64'(out_instr),   64'(q[0][31:0]));
            chk("out_illegal", 64'(out_illegal), 64'(q[0][32]));
        end
    endtask

    // Apply one cycle of stimulus, advance the model across the edge, compare
    task automatic step(input bit v, input logic [31:0] w, input bit ordy, input bit fl);
        bit push, pop;
        in_valid  = v;
        instr     = w;
        out_ready = ordy;
        flush     = fl;
        push = v && (q.size() < DEPTH) && !fl;
        pop  = (q.size() != 0) && ordy && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back({ref_illegal(w), w});
                m_acc = (m_acc + 1) & MAXC;
                if (ref_illegal(w) && m_ill != MAXC) m_ill++;
            end
        end
        compare_all();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  64'(in_ready),     64'd1);
        chk("rst_out_valid", 64'(out_valid),    64'd0);
        chk("rst_count",     64'(count),        64'd0);
        chk("rst_acc",       64'(accepted_cnt), 64'd0);
        chk("rst_ill",       64'(illegal_cnt),  64'd0);

        // First push becomes visible right after its edge
        step(1, 32'h00500093, 0, 0);
        chk("addi_instr",   64'(out_instr),   64'h00500093);
        chk("addi_illegal", 64'(out_illegal), 64'd0);
        chk("addi_acc",     64'(accepted_cnt), 64'd1);
        step(0, 0, 1, 0);

        // All-zero and all-one words are both illegal
        step(1, 32'h00000000, 0, 0);
        step(1, 32'hFFFFFFFF, 0, 0);
        chk("zero_illegal", 64'(out_illegal), 64'd1);
        step(0, 0, 1, 0);
        chk("ones_illegal", 64'(out_illegal), 64'd1);
        step(0, 0, 1, 0);
        chk("two_ill_cnt", 64'(illegal_cnt), 64'd2);

        // Fill to DEPTH, attempt a fifth push, then drain in order
        for (int i = 1; i <= DEPTH; i++) step(1, (32'(i) << 7) | 32'h13, 0, 0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step(1, 32'h00000513, 0, 0);
        chk("full_count", 64'(count), 64'(DEPTH));
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_order", 64'(out_instr), 64'((32'(i) << 7) | 32'h13));
            step(0, 0, 1, 0);
        end

        // Streaming with a continuously ready consumer
        for (int i = 0; i < 20; i++) begin
            step(1, legal_word(), 1, 0);
            chk("stream_cnt_le1", 64'(count <= 1), 64'd1);
        end
        step(0, 0, 1, 0);

        // Flush with in_valid asserted discards everything and accepts nothing
        for (int i = 0; i < 3; i++) step(1, legal_word(), 0, 0);
        step(1, 32'h00100073, 1, 1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges with two entries buffered
        step(1, legal_word(), 0, 0);
        step(1, 32'h0, 0, 0);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid),    64'd0);
        chk("arst_count",     64'(count),        64'd0);
        chk("arst_acc",       64'(accepted_cnt), 64'd0);
        chk("arst_ill",       64'(illegal_cnt),  64'd0);
        q.delete(); m_acc = 0; m_ill = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 32'h00500093, 0, 0);

        // Randomized traffic, including occasional flushes
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_word(),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
        end

        // Enough illegal pushes to saturate the illegal counter
        for (int i = 0; i < 2 * (MAXC + 1); i++) step(1, 32'h0, 1, 0);
        chk("ill_saturated", 64'(illegal_cnt), 64'(MAXC));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
